// File: rtl/control.sv
// Key-pattern player: an accepted UART word is latched onto out and held for
// C_MUSIC ms, then cleared; new words retrigger, an all-zero word is note-off.
module control #(
  parameter int C_CLK_FRQ         = 100_000_000,
  parameter int C_MUSIC           = 5,
  parameter int C_UART_DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         UART_err,
  input  logic                         UART_valid,
  input  logic [C_UART_DATA_WIDTH-1:0] UART_msg,
  output logic [C_UART_DATA_WIDTH-1:0] out
);

  // Clock rates below 1 kHz still get a one-cycle prescaler period.
  localparam int TICKS     = (C_CLK_FRQ / 1000 > 0) ? (C_CLK_FRQ / 1000) : 1;
  localparam int PRE_W     = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int MS_N      = (C_MUSIC > 0) ? C_MUSIC : 1;
  localparam int MS_W      = (MS_N > 1) ? $clog2(MS_N) : 1;
  localparam bit ZERO_HOLD = (C_MUSIC <= 0);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [C_UART_DATA_WIDTH-1:0] out_q, out_d;
  logic [PRE_W-1:0]             pre_q, pre_d;
  logic [MS_W-1:0]              ms_q, ms_d;

  logic accept;
  logic note_on;
  logic expire;

  assign accept  = UART_valid & ~UART_err;
  assign note_on = accept & (|UART_msg);
  assign expire  = ZERO_HOLD || ((pre_q == PRE_LAST) && (ms_q == MS_LAST));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      out_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    case (state_q)
      IDLE: begin
        if (note_on) begin
          state_d = PLAY;
          out_d   = UART_msg;
          pre_d   = '0;
          ms_d    = '0;
        end
      end
      PLAY: begin
        // An accepted word wins over a timer expiry in the same cycle.
        if (note_on) begin
          out_d = UART_msg;
          pre_d = '0;
          ms_d  = '0;
        end else if (accept || expire) begin
          state_d = IDLE;
          out_d   = '0;
          pre_d   = '0;
          ms_d    = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          ms_d  = ms_q + MS_W'(1);
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
        pre_d   = '0;
        ms_d    = '0;
      end
    endcase
  end

  assign out = out_q;

endmodule

// File: tb/tb_control.sv
// Bench for control: 10 kHz-scaled clock so a 5 ms note is 50 cycles; a monitor
// checks every change of out against expected (value, cycle) events.
module tb_control;

  localparam int HOLD = 50;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       rstb;
  logic       err;
  logic       vld;
  logic [7:0] msg;
  logic [7:0] out;

  int         cyc;
  int         total;
  int         bad;
  logic [7:0] prev;
  ev_t        exp_q[$];

  control #(
    .C_CLK_FRQ        (10_000),
    .C_MUSIC          (5),
    .C_UART_DATA_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .UART_err  (err),
    .UART_valid(vld),
    .UART_msg  (msg),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cyc %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every transition of out must match the head of the expected queue.
  initial prev = 8'h00;
  always @(negedge clk) begin
    if (out !== prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: out=%h at cyc %0d, required no change (stay %h)",
                 out, cyc, prev);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (out !== e.val || cyc != e.cyc) begin
          bad++;
          $display("FAIL out_event: got %h at cyc %0d, required %h at cyc %0d",
                   out, cyc, e.val, e.cyc);
        end
      end
      prev = out;
    end
  end

  task automatic push(input logic [7:0] v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int m);
    while (cyc < m) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle strobe while cyc==m; the DUT samples it on edge m+1.
  task automatic send_at(input int m, input logic [7:0] w, input logic e);
    wait_to(m);
    msg = w;
    err = e;
    vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
    err = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [7:0] req);
    total++;
    if (out !== req) begin
      bad++;
      $display("FAIL %s: out=%h, required %h", name, out, req);
    end
  endtask

  initial begin
    int n;
    int m;
    total = 0;
    bad   = 0;
    rstb  = 1'b0;
    err   = 1'b0;
    vld   = 1'b0;
    msg   = 8'h00;
    #200;
    rstb = 1'b1;
    @(posedge clk);
    #1;
    check_now("reset_out", 8'h00);

    // Idle, plus an errored word in IDLE: no change expected.
    send_at(cyc + 20, 8'hFF, 1'b1);
    wait_to(cyc + 10);

    // Single note.
    n = cyc + 2;
    push(8'h7A, n + 1);
    push(8'h00, n + 1 + HOLD);
    send_at(n, 8'h7A, 1'b0);
    wait_to(n + HOLD + 10);

    // Errored word during PLAY must not disturb out or the timer.
    n = cyc + 2;
    push(8'h7A, n + 1);
    push(8'h00, n + 1 + HOLD);
    send_at(n, 8'h7A, 1'b0);
    send_at(n + 10, 8'hFF, 1'b1);
    wait_to(n + HOLD + 10);

    // Retrigger with a different word 2 ms in.
    n = cyc + 2;
    m = n + 20;
    push(8'h7A, n + 1);
    push(8'h91, m + 1);
    push(8'h00, m + 1 + HOLD);
    send_at(n, 8'h7A, 1'b0);
    send_at(m, 8'h91, 1'b0);
    wait_to(m + HOLD + 10);

    // Retrigger with the same word extends the hold.
    n = cyc + 2;
    m = n + 30;
    push(8'h7A, n + 1);
    push(8'h00, m + 1 + HOLD);
    send_at(n, 8'h7A, 1'b0);
    send_at(m, 8'h7A, 1'b0);
    wait_to(m + HOLD + 10);

    // Explicit note-off.
    n = cyc + 2;
    m = n + 15;
    push(8'h6E, n + 1);
    push(8'h00, m + 1);
    send_at(n, 8'h6E, 1'b0);
    send_at(m, 8'h00, 1'b0);
    wait_to(m + HOLD + 10);

    // Word accepted on the exact expiry edge takes priority.
    n = cyc + 2;
    push(8'h7A, n + 1);
    push(8'h55, n + 1 + HOLD);
    push(8'h00, n + 1 + 2 * HOLD);
    send_at(n, 8'h7A, 1'b0);
    send_at(n + HOLD, 8'h55, 1'b0);
    wait_to(n + 2 * HOLD + 10);

    // Reset mid-note: out clears at once and nothing restarts.
    n = cyc + 2;
    push(8'h7A, n + 1);
    send_at(n, 8'h7A, 1'b0);
    wait_to(n + 11);
    push(8'h00, cyc);
    #1;
    rstb = 1'b0;
    #1;
    check_now("async_reset_out", 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    wait_to(cyc + HOLD + 10);
    check_now("no_restart_after_reset", 8'h00);

    // Word presented together with reset release is honoured on the first edge.
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    n = cyc;
    push(8'h3C, n + 1);
    push(8'h00, n + 1 + HOLD);
    send_at(n, 8'h3C, 1'b0);
    wait_to(n + HOLD + 10);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: %0d expected changes never seen, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter C_CLK_FRQ, default 100_000_000: clock frequency in Hz.
REQ-002 Parameter C_MUSIC, default 5: note (light/sound) hold duration in ms.
REQ-003 Parameter C_UART_DATA_WIDTH, default 8: received word width in bits.
REQ-004 clk  input  1  single system clock; all logic is on the rising edge.
REQ-005 rstb  input  1  reset, asynchronous, active-low.
REQ-006 UART_err  input  1  receiver error flag, qualifies UART_valid.
REQ-007 UART_valid  input  1  one-cycle strobe: UART_msg holds a complete received word.
REQ-008 UART_msg  input  C_UART_DATA_WIDTH  received word; one bit per key/note.
REQ-009 out  output  C_UART_DATA_WIDTH  registered key pattern driving tone/LED logic.

Function
REQ-010 The block shall sample UART_msg only in a cycle where UART_valid=1 and UART_err=0 (an accepted word); UART_msg shall be ignored in all other cycles.
REQ-011 A word with UART_valid=1 and UART_err=1 shall be discarded, with no change to out, state or timer.
REQ-012 The FSM shall have two states, IDLE and PLAY; IDLE is entered at reset.
REQ-013 IDLE: out=0; an accepted nonzero word shall load out on the next rising edge (1-cycle latency), clear the timer and move to PLAY.
REQ-014 PLAY: out shall hold the loaded word while the timer runs.
REQ-015 Timer: a 1 ms prescaler counting C_CLK_FRQ/1000 cycles, plus a ms counter up to C_MUSIC; hold length = C_MUSIC*(C_CLK_FRQ/1000) clock cycles, using integer division.
REQ-016 When the hold length has elapsed, out shall clear to 0 on that edge and the FSM shall return to IDLE.
REQ-017 An accepted nonzero word in PLAY shall replace out with the new word and restart the full hold period (retrigger); the old word shall not be merged in.
REQ-018 An accepted all-zero word in any state shall force out=0 and return to IDLE on the next edge (explicit note-off).
REQ-019 If the timer expires in the same cycle a word is accepted, the accepted word shall take priority under REQ-017/REQ-018.
REQ-020 Counter widths shall be sized with $clog2 from the parameters, with no wrap-around before terminal count; C_MUSIC=0 shall give a 1-cycle hold.
REQ-021 out shall be driven directly from a register, with no combinational path from inputs to out.

Reset
REQ-022 rstb=0 shall immediately and asynchronously set out=0, state=IDLE and both counters to 0, regardless of clk.
REQ-023 Reset asserted mid-PLAY shall abort the note; after rstb rises the block shall wait in IDLE for a new accepted word.
REQ-024 Release of rstb shall be taken synchronously to clk; the first accepted word shall be honoured on the first rising edge after release.

Verification (C_CLK_FRQ=100 MHz, C_MUSIC=5, so hold = 500_000 cycles)
REQ-025 Reset for 200 ns, then no UART_valid -> out=8'h00 throughout.
REQ-026 UART_msg=8'b01111010 with a 1-cycle UART_valid, UART_err=0 -> out=8'h7A one edge later, held 500_000 cycles, then 8'h00.
REQ-027 8'h7A accepted, then 8'b10010001 accepted 2 ms later -> out=8'h91 immediately, held 5 ms from the second strobe, then 0.
REQ-028 UART_valid=1 with UART_err=1, msg=8'hFF -> out unchanged and timer unaffected.
REQ-029 8'h6E playing, then 8'h00 accepted -> out=0 next edge, IDLE.
REQ-030 rstb pulsed low 1 ms into an 8'h7A note -> out=0 at once, no restart after release.
